mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the single-cycle MEM-stage port logic: a multi-cycle load/store engine between the EX/MEM pipeline register and a data-memory port with variable latency.
- Generates aligned addresses, byte enables and lane-shifted store data, and runs a req/ack handshake with a timeout.
- Extracts and sign- or zero-extends load data.
- Reports misalignment, illegal-size and timeout errors, and stalls the pipeline while busy.

Parameters:
- DATA_W, 32, datapath width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYC, 255, maximum cycles mem_req is held without mem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pipeline presents an operation
- in_memread  in  1  load request
- in_memwrite  in  1  store request
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64)
- in_unsigned  in  1  zero-extend the load (LBU/LHU/LWU)
- in_address  in  ADDR_W  byte address
- in_writedata  in  DATA_W  store data, right-justified
- in_ready  out  1  unit can accept an operation
- stall  out  1  in_valid & ~in_ready
- out_valid  out  1  result/status available
- out_ready  in  1  downstream accepts the result
- out_loaddata  out  DATA_W  extended load result
- out_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  address aligned to DATA_W/8 bytes
- mem_be  out  DATA_W/8  byte enables
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_ack  in  1  memory completion, valid only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Reset (synchronous): every output and internal register goes to 0; state goes to IDLE. A reset asserted mid-transaction drops mem_req at that edge, and any mem_ack in that cycle is ignored.
- FSM states: IDLE, REQ, RESP.
  - in_ready=1 only in IDLE.
- IDLE, when in_valid=1:
  - Neither read nor write asserted: the operation is consumed as a no-op and the FSM stays in IDLE.
  - Illegal operation (read and write both asserted, or size 11 with DATA_W=32): go to RESP with err=11.
  - Misaligned access (address is not a multiple of 2^size): go to RESP with err=01.
  - Otherwise: capture the operation and go to REQ.
- Latency:
  - An operation accepted at edge N presents mem_req at N+1.
  - An error detected at acceptance presents out_valid at N+1 and issues no memory request.
- REQ:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stay stable until the state is left.
  - mem_ack may arrive in the first REQ cycle.
  - On mem_ack: register the extracted load data and go to RESP with err=00. out_valid is asserted the cycle after the ack.
- Timeout:
  - A counter is cleared on entry to REQ and increments each REQ cycle without mem_ack.
  - When the counter equals TIMEOUT_CYC-1 and there is no ack, drop mem_req and go to RESP with err=10 and out_loaddata=0.
  - An ack arriving in that same cycle wins.
- RESP:
  - out_valid=1; out_loaddata and out_err are held until out_ready=1, then the FSM returns to IDLE.
  - The unit does not accept a new operation in that same cycle; back-to-back throughput is one operation per 3 cycles minimum.
- Store lanes:
  - offset = addr[log2(DATA_W/8)-1:0].
  - mem_be = ((1<<(1<<size))-1) << offset.
  - mem_wdata = in_writedata << (8*offset); lanes not enabled carry don't-care data.
- Loads:
  - mem_rdata is shifted right by 8*offset.
  - The low (8<<size) bits are taken and sign-extended, or zero-extended when in_unsigned=1.
  - A full-width load ignores in_unsigned.
  - Stores return out_loaddata=0.
- Width arithmetic is modulo 2^ADDR_W.
- Address low bits are cleared only on mem_addr; the offset is kept internally.

Test Plan:
- DATA_W=32, LB addr=0x1003, mem_rdata=0x80FF_1234, ack 2 cycles after req -> mem_be=1000, out_loaddata=0xFFFF_FF80, err=00, out_valid 1 cycle after ack.
- SH addr=0x2002, wdata=0x0000_BEEF, ack in the first REQ cycle -> mem_addr=0x2000, mem_be=1100, mem_wdata[31:16]=0xBEEF, mem_we=1, out_valid next cycle.
- LW addr=0x0006 -> no mem_req ever asserted; out_valid at N+1 with err=01; stall=1 for a second in_valid until out_ready.
- TIMEOUT_CYC=4, LHU addr=0x10, mem_ack never asserted -> mem_req high exactly 4 cycles, then err=10, out_loaddata=0; a mem_ack arriving in the 4th cycle instead yields err=00.
- DATA_W=64, LD addr=0x8 with size=11 -> mem_be=0xFF, full data returned; with DATA_W=32 the same size gives err=11. Read and write both high gives err=11.
- rst asserted in the 2nd REQ cycle with mem_ack=1 -> next cycle mem_req=0, out_valid=0, in_ready=1; no result is produced. Holding out_ready=0 for 5 cycles keeps out_loaddata stable.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Data-memory port bundle between the load/store unit and a variable
//   latency memory.
//   master modport (load/store unit side):
//     mem_req   out  request, held until ack or abort
//     mem_we    out  1 = write
//     mem_addr  out  address aligned to DATA_W/8 bytes
//     mem_be    out  byte enables
//     mem_wdata out  lane-shifted store data
//     mem_ack   in   completion, meaningful only while mem_req=1
//     mem_rdata in   read data, valid with mem_ack
//   slave modport: the same signals seen from the memory side.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Multi-cycle load/store engine between the EX/MEM pipeline register and
//   a variable-latency data-memory port. Aligns addresses, builds byte
//   enables and lane-shifted store data, runs a req/ack handshake with a
//   timeout, and returns sign/zero-extended load data plus an error code.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid            pipeline presents an operation
//     in_memread/memwrite load / store request
//     in_size             00 byte, 01 half, 10 word, 11 double (DATA_W=64)
//     in_unsigned         zero-extend the load
//     in_address          byte address
//     in_writedata        right-justified store data
//     in_ready, stall     unit idle / pipeline must hold
//     out_valid/out_ready result handshake
//     out_loaddata        extended load result (0 for stores and errors)
//     out_err             00 ok, 01 misaligned, 10 timeout, 11 illegal
//     mem                 memory port (mem_access_unit_if.master)
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_memread,
    input  logic              in_memwrite,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [DATA_W-1:0] in_writedata,
    output logic              in_ready,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_loaddata,
    output logic [1:0]        out_err,
    mem_access_unit_if.master mem
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BE_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Byte enables for an access of 2^size bytes starting at lane 'off'.
    function automatic logic [BE_W-1:0] laneEnables(input logic [1:0] size,
                                                    input logic [OFF_W-1:0] off);
        logic [BE_W-1:0] base;
        case (size)
            2'd0:    base = BE_W'(8'h01);
            2'd1:    base = BE_W'(8'h03);
            2'd2:    base = BE_W'(8'h0F);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    // Shift the addressed lanes down, keep the low 8<<size bits and extend.
    // The sign bit is located as the top bit of the keep mask so no
    // variable bit-select is needed.
    function automatic logic [DATA_W-1:0] extendLoad(input logic [DATA_W-1:0] rdata,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [1:0]        size,
                                                     input logic              uns);
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] keep;
        logic [DATA_W-1:0] topBit;
        int                nbits;
        shifted = rdata >> {off, 3'b000};
        nbits   = 8 << size;
        if (nbits >= DATA_W) begin
            return shifted;
        end
        keep   = ~({DATA_W{1'b1}} << nbits);
        topBit = keep & ~(keep >> 1);
        if (!uns && |(shifted & topBit)) begin
            return shifted | ~keep;
        end
        return shifted & keep;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  reqCnt;
    logic              opRead;
    logic [1:0]        opSize;
    logic              opUnsigned;
    logic [OFF_W-1:0]  opOffset;
    logic [DATA_W-1:0] loadData;
    logic [1:0]        errCode;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [BE_W-1:0]   memBe;
    logic [DATA_W-1:0] memWdata;

    logic [2:0]        sizeMask;
    logic              isIllegal;
    logic              isMisaligned;
    logic              hasAccess;
    logic [OFF_W-1:0]  inOffset;
    logic              timedOut;

    always_comb begin
        sizeMask = 3'b000;
        case (in_size)
            2'd0:    sizeMask = 3'b000;
            2'd1:    sizeMask = 3'b001;
            2'd2:    sizeMask = 3'b011;
            default: sizeMask = 3'b111;
        endcase
    end

    assign hasAccess    = in_memread | in_memwrite;
    assign isIllegal    = (in_memread & in_memwrite) | ((in_size == 2'b11) && (DATA_W < 64));
    assign isMisaligned = |(in_address[2:0] & sizeMask);
    assign inOffset     = in_address[OFF_W-1:0];
    assign timedOut     = (TIMEOUT_CYC != 0) && (reqCnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            reqCnt     <= '0;
            opRead     <= 1'b0;
            opSize     <= 2'b00;
            opUnsigned <= 1'b0;
            opOffset   <= '0;
            loadData   <= '0;
            errCode    <= ERR_OK;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memBe      <= '0;
            memWdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // An operation with neither read nor write is a no-op.
                    if (in_valid && hasAccess) begin
                        if (isIllegal) begin
                            state    <= ST_RESP;
                            errCode  <= ERR_ILLEGAL;
                            loadData <= '0;
                        end else if (isMisaligned) begin
                            state    <= ST_RESP;
                            errCode  <= ERR_MISALIGN;
                            loadData <= '0;
                        end else begin
                            state      <= ST_REQ;
                            reqCnt     <= '0;
                            opRead     <= in_memread;
                            opSize     <= in_size;
                            opUnsigned <= in_unsigned;
                            opOffset   <= inOffset;
                            memReq     <= 1'b1;
                            memWe      <= in_memwrite;
                            memAddr    <= in_address & ALIGN_MASK;
                            memBe      <= laneEnables(in_size, inOffset);
                            memWdata   <= in_writedata << {inOffset, 3'b000};
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem.mem_ack) begin
                        state    <= ST_RESP;
                        memReq   <= 1'b0;
                        errCode  <= ERR_OK;
                        loadData <= opRead ? extendLoad(mem.mem_rdata, opOffset, opSize, opUnsigned)
                                           : '0;
                    end else if (timedOut) begin
                        state    <= ST_RESP;
                        memReq   <= 1'b0;
                        errCode  <= ERR_TIMEOUT;
                        loadData <= '0;
                    end else begin
                        reqCnt <= reqCnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (state == ST_IDLE);
    assign stall        = in_valid & ~in_ready;
    assign out_valid    = (state == ST_RESP);
    assign out_loaddata = loadData;
    assign out_err      = errCode;

    assign mem.mem_req   = memReq;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_be    = memBe;
    assign mem.mem_wdata = memWdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Bench for mem_access_unit: a 32-bit instance with a short timeout
//   (directed table, random operations against a reference model, reset
//   and no-op sequences) and a 64-bit instance for double-word accesses.
module tb_mem_access_unit;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackDelay;   // REQ cycle index (0-based) that sees the ack
        int          hold;       // cycles out_ready stays low
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWlanes;  // store data restricted to enabled lanes
        logic [31:0] expData;
        logic [1:0]  expErr;
        int          expReqHigh; // cycles mem_req is observed high
    } opVec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance
    logic        inValid, inRead, inWrite, inUns, inReady, stallSig, outValid, outReady;
    logic [1:0]  inSize, outErr;
    logic [31:0] inAddr, inWdata, outData;
    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_memread(inRead), .in_memwrite(inWrite),
        .in_size(inSize), .in_unsigned(inUns), .in_address(inAddr),
        .in_writedata(inWdata), .in_ready(inReady), .stall(stallSig),
        .out_valid(outValid), .out_ready(outReady), .out_loaddata(outData),
        .out_err(outErr), .mem(bus32)
    );

    // 64-bit instance
    logic        inValid64, inRead64, inWrite64, inUns64, inReady64, stall64, outValid64, outReady64;
    logic [1:0]  inSize64, outErr64;
    logic [31:0] inAddr64;
    logic [63:0] inWdata64, outData64;
    mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(8)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(inValid64), .in_memread(inRead64), .in_memwrite(inWrite64),
        .in_size(inSize64), .in_unsigned(inUns64), .in_address(inAddr64),
        .in_writedata(inWdata64), .in_ready(inReady64), .stall(stall64),
        .out_valid(outValid64), .out_ready(outReady64), .out_loaddata(outData64),
        .out_err(outErr64), .mem(bus64)
    );

    int passCnt = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: expected bus and result values from address arithmetic.
    function automatic opVec_t refModel(input opVec_t v);
        longint unsigned one, bytes, off, width, raw, wd, rdv, addrv;
        one   = 1;
        bytes = one << v.size;
        addrv = v.addr;
        off   = addrv % 4;
        width = 8 * bytes;
        wd    = v.wdata;
        rdv   = v.rdata;
        v.expAddr   = 32'(addrv - off);
        v.expBe     = 4'(((one << bytes) - 1) << off);
        v.expWlanes = 32'((wd % (one << width)) << (8 * off));
        raw = (rdv >> (8 * off)) % (one << width);
        if (bytes < 4 && !v.uns && raw >= (one << (width - 1)))
            raw = raw + (one << 32) - (one << width);
        if (v.rd && v.wr)               v.expErr = 2'b11;
        else if (addrv % bytes != 0)    v.expErr = 2'b01;
        else if (v.ackDelay >= 4)       v.expErr = 2'b10;
        else                            v.expErr = 2'b00;
        v.expData = (v.expErr == 2'b00 && v.rd) ? 32'(raw) : 32'h0;
        if (v.expErr == 2'b01 || v.expErr == 2'b11) v.expReqHigh = 0;
        else v.expReqHigh = (v.ackDelay >= 4) ? 4 : v.ackDelay + 1;
        return v;
    endfunction

    // Run one operation on the 32-bit unit; starts and ends at a negedge in IDLE.
    task automatic doOp(input opVec_t v, input string tag);
        int k;
        int reqHigh;
        logic [31:0] laneMask;
        for (int b = 0; b < 4; b++) laneMask[8*b +: 8] = {8{v.expBe[b]}};
        inValid = 1'b1; inRead = v.rd; inWrite = v.wr; inSize = v.size;
        inUns = v.uns; inAddr = v.addr; inWdata = v.wdata;
        #1 check({tag, " in_ready"}, 64'(inReady), 64'd1);
        @(negedge clk);
        inValid = 1'b0;
        #1;
        if (v.expErr == 2'b01 || v.expErr == 2'b11) begin
            check({tag, " no mem_req"}, 64'(bus32.mem_req), 64'd0);
        end else begin
            check({tag, " mem_we"}, 64'(bus32.mem_we), 64'(v.wr));
            check({tag, " mem_be"}, 64'(bus32.mem_be), 64'(v.expBe));
            if (v.wr) check({tag, " mem_wdata"}, 64'(bus32.mem_wdata & laneMask), 64'(v.expWlanes));
            k = 0;
            reqHigh = 0;
            while (bus32.mem_req === 1'b1 && k < 20) begin
                reqHigh++;
                check({tag, " mem_addr"}, 64'(bus32.mem_addr), 64'(v.expAddr));
                if (k == v.ackDelay) begin
                    bus32.mem_ack = 1'b1;
                    bus32.mem_rdata = v.rdata;
                end
                @(negedge clk);
                bus32.mem_ack = 1'b0;
                bus32.mem_rdata = $urandom;
                #1;
                k++;
            end
            check({tag, " req cycles"}, 64'(reqHigh), 64'(v.expReqHigh));
        end
        // A second operation waits behind the result until out_ready.
        for (int h = 0; h <= v.hold; h++) begin
            inValid = (h < v.hold);
            outReady = (h == v.hold);
            #1;
            check({tag, " out_valid"}, 64'(outValid), 64'd1);
            check({tag, " loaddata"}, 64'(outData), 64'(v.expData));
            check({tag, " err"}, 64'(outErr), 64'(v.expErr));
            check({tag, " stall"}, 64'(stallSig), 64'(h < v.hold));
            check({tag, " resp mem_req"}, 64'(bus32.mem_req), 64'd0);
            @(negedge clk);
        end
        outReady = 1'b0;
        inValid = 1'b0;
        #1;
        check({tag, " back to idle"}, 64'(inReady), 64'd1);
        check({tag, " out_valid low"}, 64'(outValid), 64'd0);
    endtask

    // Single 64-bit operation with ack in the second REQ cycle.
    task automatic op64(input string tag, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] rdata,
                        input logic [7:0] expBe, input logic [63:0] expData,
                        input logic [1:0] expErr);
        inValid64 = 1'b1; inRead64 = 1'b1; inWrite64 = 1'b0; inSize64 = size;
        inUns64 = uns; inAddr64 = addr; inWdata64 = '0;
        @(negedge clk);
        inValid64 = 1'b0;
        #1;
        if (expErr == 2'b00) begin
            check({tag, " mem_req"}, 64'(bus64.mem_req), 64'd1);
            check({tag, " mem_be"}, 64'(bus64.mem_be), 64'(expBe));
            check({tag, " mem_addr"}, 64'(bus64.mem_addr), 64'(addr & 32'hFFFF_FFF8));
            @(negedge clk);
            bus64.mem_ack = 1'b1;
            bus64.mem_rdata = rdata;
            @(negedge clk);
            bus64.mem_ack = 1'b0;
            #1;
        end else begin
            check({tag, " no mem_req"}, 64'(bus64.mem_req), 64'd0);
        end
        check({tag, " out_valid"}, 64'(outValid64), 64'd1);
        check({tag, " loaddata"}, outData64, expData);
        check({tag, " err"}, 64'(outErr64), 64'(expErr));
        outReady64 = 1'b1;
        @(negedge clk);
        outReady64 = 1'b0;
    endtask

    opVec_t tbl[13];
    opVec_t v;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80FF1234, 2, 0,
                    32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80, 2'b00, 3};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000BEEF, 32'h0, 0, 0,
                    32'h2000, 4'b1100, 32'hBEEF0000, 32'h0, 2'b00, 1};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0006, 32'h0, 32'h0, 0, 2,
                    32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 0};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0010, 32'h0, 32'h0000FFFF, 9, 0,
                    32'h0010, 4'b0011, 32'h0, 32'h0, 2'b10, 4};
        tbl[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0010, 32'h0, 32'h1234F00D, 3, 0,
                    32'h0010, 4'b0011, 32'h0, 32'h0000F00D, 2'b00, 4};
        tbl[5]  = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h0008, 32'h0, 32'h0, 0, 0,
                    32'h0, 4'b0000, 32'h0, 32'h0, 2'b11, 0};
        tbl[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0004, 32'h0, 32'h0, 0, 0,
                    32'h0, 4'b0000, 32'h0, 32'h0, 2'b11, 0};
        tbl[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0002, 32'h0, 32'h80010000, 1, 0,
                    32'h0000, 4'b1100, 32'h0, 32'hFFFF8001, 2'b00, 2};
        tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0001, 32'h0, 32'h00009A00, 1, 0,
                    32'h0000, 4'b0010, 32'h0, 32'h0000009A, 2'b00, 2};
        tbl[9]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h0004, 32'h0, 32'hDEADBEEF, 0, 0,
                    32'h0004, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00, 1};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0003, 32'h123456A5, 32'h0, 1, 0,
                    32'h0000, 4'b1000, 32'hA5000000, 32'h0, 2'b00, 2};
        tbl[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h7F00FF01, 1, 5,
                    32'hFFFFFFFC, 4'b1111, 32'h0, 32'h7F00FF01, 2'b00, 2};
        tbl[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0001, 32'h0000FFFF, 32'h0, 0, 1,
                    32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 0};

        rst = 1'b1;
        inValid = 1'b0; inRead = 1'b0; inWrite = 1'b0; inSize = 2'd0; inUns = 1'b0;
        inAddr = '0; inWdata = '0; outReady = 1'b0;
        inValid64 = 1'b0; inRead64 = 1'b0; inWrite64 = 1'b0; inSize64 = 2'd0; inUns64 = 1'b0;
        inAddr64 = '0; inWdata64 = '0; outReady64 = 1'b0;
        bus32.mem_ack = 1'b0; bus32.mem_rdata = '0;
        bus64.mem_ack = 1'b0; bus64.mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", 64'(inReady), 64'd1);
        check("reset out_valid", 64'(outValid), 64'd0);
        check("reset mem_req", 64'(bus32.mem_req), 64'd0);
        check("reset out_err", 64'(outErr), 64'd0);
        check("reset loaddata", 64'(outData), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) doOp(tbl[i], $sformatf("vec%0d", i));

        // No-op: neither read nor write is consumed without leaving IDLE.
        inValid = 1'b1; inRead = 1'b0; inWrite = 1'b0; inAddr = 32'h40;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        check("noop in_ready", 64'(inReady), 64'd1);
        check("noop out_valid", 64'(outValid), 64'd0);
        check("noop mem_req", 64'(bus32.mem_req), 64'd0);
        @(negedge clk);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [31:0] am;
            r = $urandom_range(0, 9);
            v.rd = (r == 0) || (r < 5);
            v.wr = (r == 0) || (r >= 5);
            v.size = 2'($urandom_range(0, 2));
            v.uns = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            am = (32'd1 << v.size) - 32'd1;
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~am;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.ackDelay = $urandom_range(0, 5);
            v.hold = $urandom_range(0, 2);
            v = refModel(v);
            doOp(v, $sformatf("rnd%0d", i));
        end

        // Reset in the second REQ cycle with an ack present: no result.
        inValid = 1'b1; inRead = 1'b1; inWrite = 1'b0; inSize = 2'd2; inAddr = 32'h80;
        @(negedge clk);
        inValid = 1'b0;
        #1 check("rst-mid mem_req before", 64'(bus32.mem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus32.mem_ack = 1'b1;
        bus32.mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        rst = 1'b0;
        bus32.mem_ack = 1'b0;
        #1;
        check("rst-mid mem_req", 64'(bus32.mem_req), 64'd0);
        check("rst-mid out_valid", 64'(outValid), 64'd0);
        check("rst-mid in_ready", 64'(inReady), 64'd1);
        check("rst-mid loaddata", 64'(outData), 64'd0);
        repeat (3) @(negedge clk);
        #1 check("rst-mid no late result", 64'(outValid), 64'd0);
        @(negedge clk);

        // 64-bit datapath.
        op64("ld64", 2'd3, 1'b0, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF, 2'b00);
        op64("lw64", 2'd2, 1'b0, 32'hC, 64'h80000000_12345678, 8'hF0, 64'hFFFFFFFF_80000000, 2'b00);
        op64("ld64 mis", 2'd3, 1'b0, 32'h4, 64'h0, 8'h00, 64'h0, 2'b01);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
